// File: rtl/cmac_pkg.sv
// cmac_pkg: shared mode encoding and complex operand types for complex_mac_pipe.
// Saturating accumulation is selected at build time with CMAC_SATURATE_EN.
package cmac_pkg;

  localparam int CMAC_DATA_W = 16;
  localparam int CMAC_ACC_W  = 40;

  // 2'b11 is not a member and decodes as MUL.
  typedef enum logic [1:0] {
    MUL     = 2'b00,
    MAC     = 2'b01,
    MAC_CLR = 2'b10
  } mode_e;

  typedef struct packed {
    logic signed [CMAC_DATA_W-1:0] re;
    logic signed [CMAC_DATA_W-1:0] im;
  } cplx_in_t;

  typedef struct packed {
    logic signed [CMAC_ACC_W-1:0] re;
    logic signed [CMAC_ACC_W-1:0] im;
  } cplx_acc_t;

endpackage

// File: rtl/complex_mac_pipe_lane.sv
// cmac_lane: one lane's products (S2), sum and accumulator (S3), sticky overflow.
// CMAC_SATURATE_EN clamps MAC results instead of wrapping.
module cmac_lane
  import cmac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                pp_en_i,
  input  logic                acc_en_i,
  input  logic [2*DATA_W-1:0] a_i,
  input  logic [2*DATA_W-1:0] b_i,
  input  mode_e               mode_i,
  input  logic                conj_i,
  output logic [2*ACC_W-1:0]  result_o,
  output logic                ovf_o
);

  localparam int PW = 2*DATA_W;

`ifdef CMAC_SATURATE_EN
  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  logic signed [DATA_W-1:0] ar, ai, br, bi;
  logic signed [PW-1:0] rr_d, ii_d, ir_d, ri_d;
  logic signed [PW-1:0] rr_q, ii_q, ir_q, ri_q;
  logic signed [PW:0] sr, si;
  logic signed [ACC_W-1:0] pr, pi, mr, mi;
  logic [ACC_W:0] tr, ti;
  logic or_v, oi_v;
  logic [ACC_W-1:0] acc_re_d, acc_im_d, acc_re_q, acc_im_q;
  logic [ACC_W-1:0] res_re_d, res_im_d, res_re_q, res_im_q;
  logic ovf_d, ovf_q;

  assign ar = a_i[PW-1:DATA_W];
  assign ai = a_i[DATA_W-1:0];
  assign br = b_i[PW-1:DATA_W];
  assign bi = b_i[DATA_W-1:0];

  always_comb begin
    rr_d = rr_q;
    ii_d = ii_q;
    ir_d = ir_q;
    ri_d = ri_q;
    if (pp_en_i) begin
      rr_d = PW'(ar) * PW'(br);
      ii_d = PW'(ai) * PW'(bi);
      ir_d = PW'(ai) * PW'(br);
      ri_d = PW'(ar) * PW'(bi);
    end
  end

  // Conjugate flips the sign of the combine, never the operand.
  always_comb begin
    if (conj_i) begin
      sr = (PW+1)'(rr_q) + (PW+1)'(ii_q);
      si = (PW+1)'(ir_q) - (PW+1)'(ri_q);
    end else begin
      sr = (PW+1)'(rr_q) - (PW+1)'(ii_q);
      si = (PW+1)'(ir_q) + (PW+1)'(ri_q);
    end
    pr = ACC_W'(sr);
    pi = ACC_W'(si);
    tr = (ACC_W+1)'($signed(acc_re_q)) + (ACC_W+1)'(pr);
    ti = (ACC_W+1)'($signed(acc_im_q)) + (ACC_W+1)'(pi);
    or_v = tr[ACC_W] ^ tr[ACC_W-1];
    oi_v = ti[ACC_W] ^ ti[ACC_W-1];
    mr = tr[ACC_W-1:0];
    mi = ti[ACC_W-1:0];
`ifdef CMAC_SATURATE_EN
    if (or_v) mr = tr[ACC_W] ? MIN_V : MAX_V;
    if (oi_v) mi = ti[ACC_W] ? MIN_V : MAX_V;
`endif
  end

  always_comb begin
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    res_re_d = res_re_q;
    res_im_d = res_im_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      acc_re_d = '0;
      acc_im_d = '0;
      ovf_d    = 1'b0;
    end else if (acc_en_i) begin
      unique case (1'b1)
        mode_i == MAC_CLR: begin
          acc_re_d = pr;
          acc_im_d = pi;
          res_re_d = pr;
          res_im_d = pi;
          ovf_d    = 1'b0;
        end
        mode_i == MAC: begin
          acc_re_d = mr;
          acc_im_d = mi;
          res_re_d = mr;
          res_im_d = mi;
          ovf_d    = ovf_q | or_v | oi_v;
        end
        default: begin
          res_re_d = pr;
          res_im_d = pi;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      ii_q     <= '0;
      ir_q     <= '0;
      ri_q     <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      res_re_q <= '0;
      res_im_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      ii_q     <= ii_d;
      ir_q     <= ir_d;
      ri_q     <= ri_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      res_re_q <= res_re_d;
      res_im_q <= res_im_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result_o = {res_re_q, res_im_q};
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/complex_mac_pipe.sv
// complex_mac_pipe: 3-stage complex multiply/MAC over LANES lanes with handshake.
// Define CMAC_SATURATE_EN for saturating accumulation (wraps otherwise).
module complex_mac_pipe
  import cmac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int LANES  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [LANES*2*DATA_W-1:0] a_i,
  input  logic [LANES*2*DATA_W-1:0] b_i,
  input  mode_e                    mode_i,
  input  logic                     conj_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     flush_i,
  output logic [LANES*2*ACC_W-1:0] result_o,
  output logic [LANES-1:0]         ovf_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     busy_o
);

  localparam int IW = LANES*2*DATA_W;

  logic en, accept;
  logic s1v_d, s1v_q, s2v_d, s2v_q, s3v_d, s3v_q;
  logic [IW-1:0] a_d, a_q, b_d, b_q;
  mode_e m1_d, m1_q, m2_d, m2_q;
  logic c1_d, c1_q, c2_d, c2_q;

  // One global enable: the whole pipe freezes while the output is held.
  always_comb begin
    en         = !s3v_q || out_ready_i;
    in_ready_o = en && !flush_i;
    accept     = in_valid_i && in_ready_o;
    s1v_d = s1v_q;
    s2v_d = s2v_q;
    s3v_d = s3v_q;
    a_d   = a_q;
    b_d   = b_q;
    m1_d  = m1_q;
    c1_d  = c1_q;
    m2_d  = m2_q;
    c2_d  = c2_q;
    if (en) begin
      s1v_d = accept;
      a_d   = a_i;
      b_d   = b_i;
      m1_d  = mode_i;
      c1_d  = conj_i;
      s2v_d = s1v_q;
      m2_d  = m1_q;
      c2_d  = c1_q;
      s3v_d = s2v_q;
    end
    if (flush_i) begin
      s1v_d = 1'b0;
      s2v_d = 1'b0;
      s3v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1v_q <= 1'b0;
      s2v_q <= 1'b0;
      s3v_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      m1_q  <= MUL;
      c1_q  <= 1'b0;
      m2_q  <= MUL;
      c2_q  <= 1'b0;
    end else begin
      s1v_q <= s1v_d;
      s2v_q <= s2v_d;
      s3v_q <= s3v_d;
      a_q   <= a_d;
      b_q   <= b_d;
      m1_q  <= m1_d;
      c1_q  <= c1_d;
      m2_q  <= m2_d;
      c2_q  <= c2_d;
    end
  end

  assign out_valid_o = s3v_q;
  assign busy_o      = s1v_q | s2v_q | s3v_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cmac_lane #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .pp_en_i (en),
      .acc_en_i(en && s2v_q),
      .a_i     (a_q[g*2*DATA_W +: 2*DATA_W]),
      .b_i     (b_q[g*2*DATA_W +: 2*DATA_W]),
      .mode_i  (m2_q),
      .conj_i  (c2_q),
      .result_o(result_o[g*2*ACC_W +: 2*ACC_W]),
      .ovf_o   (ovf_o[g])
    );
  end

endmodule

// File: tb/tb_complex_mac_pipe.sv
// tb_complex_mac_pipe: directed and random stimulus against a queue-based
// arithmetic model of the complex MAC pipe (DATA_W=16, ACC_W=34, LANES=2).
`timescale 1ns/1ps
module tb_complex_mac_pipe;
  import cmac_pkg::*;

  localparam int DW = 16;
  localparam int AW = 34;
  localparam int L  = 2;
  localparam int IW = L*2*DW;
  localparam int RW = L*2*AW;
  localparam longint AMAX = 64'sd8589934591;
  localparam longint AMIN = -64'sd8589934592;
  localparam longint AMOD = 64'sd17179869184;

  logic clk, rst;
  logic [IW-1:0] a, b;
  mode_e mode;
  logic conj, in_valid, in_ready, flush;
  logic [RW-1:0] result;
  logic [L-1:0] ovf;
  logic out_valid, out_ready, busy;

  complex_mac_pipe #(.DATA_W(DW), .ACC_W(AW), .LANES(L)) dut (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .mode_i(mode),
    .conj_i(conj), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .flush_i(flush), .result_o(result), .ovf_o(ovf),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] a;
    logic [IW-1:0] b;
    mode_e mode;
    logic conj;
  } txn_t;

  txn_t q[$];
  logic [RW-1:0] obs[$];
  longint m_acc[L][2];
  bit m_ovf[L];
  longint n_acc[L][2];
  bit n_ovf[L];
  logic [RW-1:0] n_res;
  int tests, fails, acc_cnt;
  bit hold_chk;
  logic [RW-1:0] held;

  task automatic chk(string nm, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkv(string nm, logic [RW-1:0] act, logic [RW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic longint opf(logic [IW-1:0] v, int l, int im);
    logic signed [DW-1:0] t;
    t = v[l*2*DW + (im != 0 ? 0 : DW) +: DW];
    return longint'(t);
  endfunction

  function automatic longint rf(logic [RW-1:0] v, int l, int im);
    logic signed [AW-1:0] t;
    t = v[l*2*AW + (im != 0 ? 0 : AW) +: AW];
    return longint'(t);
  endfunction

  function automatic logic [IW-1:0] op(int r0, int i0, int r1, int i1);
    cplx_in_t [L-1:0] v;
    v[0].re = DW'(r0);
    v[0].im = DW'(i0);
    v[1].re = DW'(r1);
    v[1].im = DW'(i1);
    return v;
  endfunction

  function automatic longint fold(input longint s, output bit of);
    of = 1'b0;
    if (s > AMAX) begin
      of = 1'b1;
`ifdef CMAC_SATURATE_EN
      return AMAX;
`else
      return s - AMOD;
`endif
    end
    if (s < AMIN) begin
      of = 1'b1;
`ifdef CMAC_SATURATE_EN
      return AMIN;
`else
      return s + AMOD;
`endif
    end
    return s;
  endfunction

  // Reference: complex arithmetic on plain integers, applied in arrival order.
  function automatic void eval(input txn_t t);
    longint ar, ai, br, bi, r;
    longint p[2];
    bit of;
    for (int l = 0; l < L; l++) begin
      ar = opf(t.a, l, 0);
      ai = opf(t.a, l, 1);
      br = opf(t.b, l, 0);
      bi = opf(t.b, l, 1);
      p[0] = t.conj ? ar*br + ai*bi : ar*br - ai*bi;
      p[1] = t.conj ? ai*br - ar*bi : ai*br + ar*bi;
      n_ovf[l] = (t.mode == MAC_CLR) ? 1'b0 : m_ovf[l];
      for (int c = 0; c < 2; c++) begin
        n_acc[l][c] = m_acc[l][c];
        r = p[c];
        if (t.mode == MAC_CLR) begin
          n_acc[l][c] = r;
        end else if (t.mode == MAC) begin
          r = fold(m_acc[l][c] + p[c], of);
          if (of) n_ovf[l] = 1'b1;
          n_acc[l][c] = r;
        end
        n_res[l*2*AW + (c == 0 ? AW : 0) +: AW] = AW'(r);
      end
    end
  endfunction

  task automatic model_clear();
    q.delete();
    for (int l = 0; l < L; l++) begin
      m_ovf[l] = 1'b0;
      m_acc[l][0] = 0;
      m_acc[l][1] = 0;
    end
    hold_chk = 1'b0;
  endtask

  always @(posedge rst) model_clear();

  // Edge bookkeeping: inputs are stable here (driven at negedge).
  always @(posedge clk) begin
    if (!rst) begin
      if (flush) begin
        model_clear();
      end else begin
        if (out_valid && out_ready) begin
          if (q.size() != 0) begin
            eval(q[0]);
            m_acc = n_acc;
            m_ovf = n_ovf;
            void'(q.pop_front());
          end
          obs.push_back(result);
        end
        if (in_valid && in_ready) begin
          q.push_back('{a: a, b: b, mode: mode, conj: conj});
          acc_cnt++;
        end
      end
      if (out_valid && !out_ready) chk("stall_in_ready", longint'(in_ready), 0);
      hold_chk = out_valid && !out_ready && !flush;
      held = result;
    end
  end

  // Output compare, half a cycle after the active edge.
  always @(negedge clk) begin
    logic [L-1:0] eo;
    if (!rst) begin
      if (hold_chk) begin
        chk("hold_valid", longint'(out_valid), 1);
        chkv("hold_result", result, held);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          eval(q[0]);
          for (int l = 0; l < L; l++) eo[l] = n_ovf[l];
          chkv("model_result", result, n_res);
          chk("model_ovf", longint'(ovf), longint'(eo));
        end
      end
    end
  end

  task automatic send(logic [IW-1:0] ta, logic [IW-1:0] tb, mode_e tm, logic tc);
    int n0;
    n0 = acc_cnt;
    a = ta;
    b = tb;
    mode = tm;
    conj = tc;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && acc_cnt == n0; i++) @(negedge clk);
    if (acc_cnt == n0) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q.size() != 0 || busy); i++) @(negedge clk);
    chk("drain", longint'(q.size() == 0 && !busy), 1);
  endtask

  task automatic chk_obs(string nm, int idx, longint r0, longint i0, longint r1, longint i1);
    if (obs.size() <= idx) begin
      chk({nm, "_present"}, obs.size(), idx + 1);
    end else begin
      chk({nm, "_l0re"}, rf(obs[idx], 0, 0), r0);
      chk({nm, "_l0im"}, rf(obs[idx], 0, 1), i0);
      chk({nm, "_l1re"}, rf(obs[idx], 1, 0), r1);
      chk({nm, "_l1im"}, rf(obs[idx], 1, 1), i1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, c0;
    logic [IW-1:0] pa, pb, one, big;
    tests = 0;
    fails = 0;
    acc_cnt = 0;
    rst = 1'b1;
    a = '0;
    b = '0;
    mode = MUL;
    conj = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    pa = op(3, 4, 0, 1);
    pb = op(1, 2, 0, 1);
    one = op(1, 0, 1, 0);
    big = op(-32768, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chkv("rst_result", result, '0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_busy", longint'(busy), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    @(negedge clk);

    n = obs.size();
    send(pa, pb, MUL, 1'b0);
    k = 1;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("t1_latency", longint'(k), 3);
    drain();
    chk_obs("t1_mul", n, -5, 10, -1, 0);

    n = obs.size();
    send(pa, pb, MUL, 1'b1);
    drain();
    chk_obs("t2_conj", n, 11, -2, 1, 0);

    n = obs.size();
    send(pa, pb, MAC_CLR, 1'b0);
    send(pa, pb, MAC, 1'b0);
    send(pa, pb, MAC, 1'b0);
    send(one, one, MUL, 1'b0);
    send(pa, pb, MAC, 1'b0);
    drain();
    chk_obs("t3_b0", n, -5, 10, -1, 0);
    chk_obs("t3_b1", n + 1, -10, 20, -2, 0);
    chk_obs("t3_b2", n + 2, -15, 30, -3, 0);
    chk_obs("t3_mul", n + 3, 1, 0, 1, 0);
    chk_obs("t3_b4", n + 4, -20, 40, -4, 0);

    n = obs.size();
    fork
      begin
        send(pa, pb, MAC_CLR, 1'b0);
        repeat (3) send(pa, pb, MAC, 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t4_count", obs.size(), n + 4);
    chk_obs("t4_b1", n + 1, -10, 20, -2, 0);
    chk_obs("t4_b3", n + 3, -20, 40, -4, 0);

    n = obs.size();
    send(big, big, MAC_CLR, 1'b0);
    repeat (7) send(big, big, MAC, 1'b0);
    drain();
    chk_obs("t5_b6", n + 6, 64'sd7516192768, 0, 0, 0);
`ifdef CMAC_SATURATE_EN
    chk_obs("t5_b7", n + 7, AMAX, 0, 0, 0);
`else
    chk_obs("t5_b7", n + 7, AMIN, 0, 0, 0);
`endif
    chk("t5_ovf", longint'(ovf), 1);
    send(one, one, MAC_CLR, 1'b0);
    drain();
    chk("t5_ovf_clr", longint'(ovf), 0);

    n = obs.size();
    repeat (3) send(pa, pb, MAC, 1'b0);
    chk("t6_busy_pre", longint'(busy), 1);
    a = one;
    b = one;
    mode = MAC;
    in_valid = 1'b1;
    flush = 1'b1;
    c0 = acc_cnt;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t6_no_accept", longint'(acc_cnt), longint'(c0));
    chk("t6_busy", longint'(busy), 0);
    chk("t6_valid", longint'(out_valid), 0);
    chk("t6_dropped", obs.size(), n);
    send(one, one, MAC, 1'b0);
    drain();
    chk_obs("t6_after", n, 1, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      mode = mode_e'(2'($urandom_range(0, 3)));
      conj = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 59) == 0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drain();

    send(pa, pb, MAC_CLR, 1'b0);
    send(pa, pb, MAC, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", longint'(out_valid), 0);
    chkv("t7_rst_result", result, '0);
    chk("t7_rst_ovf", longint'(ovf), 0);
    chk("t7_rst_busy", longint'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n = obs.size();
    send(one, one, MAC, 1'b0);
    drain();
    chk_obs("t7_after", n, 1, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/complex_mac_pipe.md
Name: complex_mac_pipe

Overview:
- Parametrised, pipelined fixed-point complex multiply/multiply-accumulate unit with LANES independent complex lanes.
- Per lane it computes the product (a × b), or (a × conj(b)), and either returns it directly or adds it into a per-lane accumulator.
- Valid/ready in/out handshake, flush and busy, so it drops into the same datapath slots as the FP complex multiply wrapper.

Parameters:
- DATA_W, 16, signed width of each real/imag operand component.
- ACC_W, 40, signed width of each accumulator/result component; must be ≥ 2*DATA_W+2.
- LANES, 2, number of parallel complex lanes.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- a_i  in  LANES*2*DATA_W  operand a per lane, packed [lane][re,im], signed.
- b_i  in  LANES*2*DATA_W  operand b per lane, same packing.
- mode_i  in  2  cmac_pkg::mode_e: MUL, MAC, MAC_CLR.
- conj_i  in  1  use conj(b).
- in_valid_i  in  1  input valid.
- in_ready_o  out  1  input ready.
- flush_i  in  1  kill in-flight work and clear accumulators.
- result_o  out  LANES*2*ACC_W  result per lane [re,im], signed.
- ovf_o  out  LANES  per-lane sticky overflow flag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result accepted.
- busy_o  out  1  any stage valid.

Behaviour:
- Pipeline: S1 operand register, S2 four signed products per lane, S3 add/sub + accumulate into the output register.
- Latency is 3 cycles from accepted input to out_valid_o when there are no stalls. Throughput is 1 per cycle.
- Global stall: en = !out_valid_o || out_ready_i. All stages advance only when en=1.
- in_ready_o = en && !flush_i. An input is accepted on in_valid_i && in_ready_o.
- Bubbles advance; valid bits travel with data.
- Products per lane (2*DATA_W bits): pp_rr=ar*br, pp_ii=ai*bi, pp_ir=ai*br, pp_ri=ar*bi.
- Normal product: re = pp_rr - pp_ii, im = pp_ir + pp_ri.
- conj_i=1: re = pp_rr + pp_ii, im = pp_ir - pp_ri. No operand negation is used, so -2^(DATA_W-1) is safe.
- Sums are sign-extended to ACC_W.
- S3 update, by mode:
  - MUL: result = product; accumulator unchanged.
  - MAC_CLR: acc = product; result = acc.
  - MAC: acc = acc + product; result = acc.
- Overflow: if acc + product exceeds the ACC_W signed range, the value wraps (two's complement) and ovf_o[lane] sets.
- ovf_o is cleared only by MAC_CLR on that lane, flush_i, or reset.
- mode_i and conj_i are captured with the operands and travel down the pipe.
- Output holds stable while out_valid_o && !out_ready_i (AXI-style). Accumulators do not update while stalled.
- flush_i (synchronous) clears all stage valids, out_valid_o, accumulators and ovf_o on the next edge.
- flush_i has priority over a simultaneous in_valid_i, which is not accepted, and over a pending output, which is dropped.
- busy_o = S1v | S2v | S3v (S3v = out_valid_o).
- Reset values: out_valid_o=0, result_o=0, ovf_o=0, busy_o=0, accumulators=0, stage valids=0. in_ready_o=1 after reset (combinational).
- Reset mid-operation discards everything; the first input after reset starts with acc=0.

Optional Feature:
- CMAC_SATURATE_EN defined:
  - MAC and MAC_CLR results clamp to +2^(ACC_W-1)-1 / -2^(ACC_W-1) instead of wrapping.
  - ovf_o still sets on any clamp.
  - The clamped value is stored in the accumulator.
- Not defined: wrap behaviour as above. Saturation logic is not instantiated.

Decomposition:
- cmac_pkg holds:
  - mode_e (MUL=2'b00, MAC=2'b01, MAC_CLR=2'b10; 2'b11 treated as MUL).
  - Per-lane packed typedefs cplx_in_t {re,im} and cplx_acc_t {re,im}.
- Sub-module cmac_lane: one lane's S2 products, S3 sum, accumulator and overflow.
  - It takes the stage enables/valids from the parent.
- complex_mac_pipe owns handshake, valid pipeline, flush and the LANES generate loop.

Test Plan:
1. DATA_W=16, LANES=2; lane0 a=3+4i, b=1+2i, MUL, conj=0 -> out_valid_o exactly 3 cycles after accept, result -5+10i. Lane1 a=0+1i, b=0+1i -> -1+0i.
2. Same a/b with conj_i=1 -> 11-2i.
3. MAC_CLR then MAC, MAC, back-to-back with a=3+4i, b=1+2i -> -5+10i, -10+20i, -15+30i. A following MUL of 1+0i × 1+0i returns 1+0i and the next MAC gives -20+40i.
4. Backpressure: out_ready_i=0 for 5 cycles during a 4-beat MAC stream -> result_o holds, in_ready_o=0, no beats lost or duplicated; final acc equals 4× product.
5. ACC_W=34, a=b=-32768+0i; MAC_CLR then 7×MAC:
   - Without CMAC_SATURATE_EN: the 8th re = -2^33 wraps and ovf_o[0]=1.
   - With CMAC_SATURATE_EN: re = 2^33-1 and ovf_o[0]=1.
6. Flush with 3 beats in flight and in_valid_i=1 -> input not accepted, busy_o=0 next cycle, and the next MAC of 1+0i × 1+0i yields 1+0i. Async rst_i pulse mid-stream -> outputs 0 immediately.
